// File: rtl/instr_packer_if.sv
// ---------------------------------------------------------------------------
// instr_packer_if
//
// Bundles the two handshaked paths of the instruction packer:
//   * field bundle in : fmt/opc/rs/rt/rd/sa/fun/imm/iindex/raw/last with
//                       in_valid (producer -> packer) and in_ready (packer ->
//                       producer).
//   * memory write out: mem_we/mem_addr/mem_wdata (packer -> memory) with
//                       mem_ack (memory -> packer).
//
// Modports:
//   master : the packer. It masters the instruction-memory write bus and
//            consumes field bundles.
//   slave  : the environment. It supplies bundles and answers writes.
// ---------------------------------------------------------------------------
interface instr_packer_if #(
  parameter int ADDR_W = 8
);

  // Field bundle
  logic [1:0]        fmt;
  logic [5:0]        opc;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        sa;
  logic [5:0]        fun;
  logic [15:0]       imm;
  logic [25:0]       iindex;
  logic [31:0]       raw;
  logic              last;
  logic              in_valid;
  logic              in_ready;

  // Instruction-memory write port
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;

  modport master (
    input  fmt, opc, rs, rt, rd, sa, fun, imm, iindex, raw, last, in_valid,
    output in_ready,
    output mem_we, mem_addr, mem_wdata,
    input  mem_ack
  );

  modport slave (
    output fmt, opc, rs, rt, rd, sa, fun, imm, iindex, raw, last, in_valid,
    input  in_ready,
    input  mem_we, mem_addr, mem_wdata,
    output mem_ack
  );

endinterface

// File: rtl/instr_packer.sv
// ---------------------------------------------------------------------------
// instr_packer
//
// Packs MIPS-style instruction fields into 32-bit words and writes them to
// consecutive instruction-memory word addresses, starting at BASE_ADDR, for
// the duration of one load session.
//
// A session is opened by start (only while idle). Each accepted bundle is
// packed according to fmt, held on the memory write port until mem_ack, and
// then the pointer advances. The session closes when a bundle marked last has
// been written, or when the word at the all-ones address has been written
// (address exhaustion, reported through the sticky full flag).
//
// Parameters:
//   ADDR_W    : instruction-memory word-address width.
//   BASE_ADDR : first word address written in every session.
//
// Ports:
//   clk    : clock, all state changes on the rising edge.
//   rst_n  : asynchronous active-low reset.
//   start  : opens a session; ignored unless idle.
//   bus    : field-bundle handshake (in) and memory write bus (out),
//            see instr_packer_if.
//   busy   : high whenever a session is open (every state but IDLE).
//   done   : one-cycle pulse when a session closes.
//   full   : session closed because the address space ran out; holds until
//            the next accepted start.
//   count  : words written in the current or most recent session.
// ---------------------------------------------------------------------------
module instr_packer #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  instr_packer_if.master    bus,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] BASE_PTR = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] TOP_PTR  = {ADDR_W{1'b1}};

  localparam logic [1:0] FMT_R   = 2'd0;
  localparam logic [1:0] FMT_I   = 2'd1;
  localparam logic [1:0] FMT_J   = 2'd2;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q,   ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q,  full_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              last_q,  last_d;

  // -------------------------------------------------------------------------
  // Field packing. Opcode always occupies [31:26]; the remaining 26 bits are
  // laid out by format. RAW bypasses packing entirely.
  // -------------------------------------------------------------------------
  function automatic logic [31:0] pack_word(
    input logic [1:0]  f,
    input logic [5:0]  op,
    input logic [4:0]  r_s,
    input logic [4:0]  r_t,
    input logic [4:0]  r_d,
    input logic [4:0]  sh,
    input logic [5:0]  fn,
    input logic [15:0] im,
    input logic [25:0] idx,
    input logic [31:0] rw
  );
    logic [31:0] w;
    case (f)
      FMT_R:   w = {op, r_s, r_t, r_d, sh, fn};
      FMT_I:   w = {op, r_s, r_t, im};
      FMT_J:   w = {op, idx};
      default: w = rw;
    endcase
    return w;
  endfunction

  // -------------------------------------------------------------------------
  // Next-state and datapath update
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    full_d  = full_q;
    wdata_d = wdata_q;
    last_d  = last_q;

    case (state_q)
      IDLE: begin
        // count and full survive here so software can read the result of
        // the previous session; they are only cleared by a new session.
        if (start) begin
          ptr_d   = BASE_PTR;
          count_d = '0;
          full_d  = 1'b0;
          state_d = ACCEPT;
        end
      end

      ACCEPT: begin
        if (bus.in_valid) begin
          wdata_d = pack_word(bus.fmt, bus.opc, bus.rs, bus.rt, bus.rd,
                              bus.sa, bus.fun, bus.imm, bus.iindex, bus.raw);
          last_d  = bus.last;
          state_d = WRITE;
        end
      end

      WRITE: begin
        if (bus.mem_ack) begin
          count_d = count_q + 1'b1;
          // A bundle marked last closes the session normally even when it
          // also landed on the top address, so full stays clear then.
          if (last_q) begin
            state_d = DONE;
          end else if (ptr_q == TOP_PTR) begin
            full_d  = 1'b1;
            state_d = DONE;
          end else begin
            ptr_d   = ptr_q + 1'b1;
            state_d = ACCEPT;
          end
        end
      end

      DONE: begin
        // start is deliberately not looked at here: a start coinciding with
        // the done pulse is dropped rather than queued.
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers. Reset abandons any in-flight write outright.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= BASE_PTR;
      count_q <= '0;
      full_q  <= 1'b0;
      wdata_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: registers, or single-compare decodes of the state register.
  // -------------------------------------------------------------------------
  assign bus.in_ready  = (state_q == ACCEPT);
  assign bus.mem_we    = (state_q == WRITE);
  assign bus.mem_addr  = ptr_q;
  assign bus.mem_wdata = wdata_q;

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign full  = full_q;
  assign count = count_q;

endmodule

// File: tb/tb_instr_packer.sv
`timescale 1ns/1ps
module tb_instr_packer;

  localparam int ADDR_W    = 2;
  localparam int BASE_ADDR = 0;
  localparam int DEPTH     = 1 << ADDR_W;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            busy;
  logic            done;
  logic            full;
  logic [ADDR_W:0] count;

  instr_packer_if #(.ADDR_W(ADDR_W)) bus ();

  instr_packer #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .full  (full),
    .count (count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  fmt;
    logic [5:0]  opc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [5:0]  fun;
    logic [15:0] imm;
    logic [25:0] iindex;
    logic [31:0] raw;
    logic        last;
  } bundle_t;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  int  n_checks = 0;
  int  n_errors = 0;
  int  ack_prob = 0;
  bit  spam     = 1'b0;
  wr_t log_q[$];

  // Reference model state
  bit          m_busy, m_have, m_done, m_full, m_last;
  int          m_ptr, m_count;
  logic [31:0] m_wdata;
  logic              p_we;
  logic [ADDR_W-1:0] p_addr;
  logic [31:0]       p_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction word from the field rules, by plain arithmetic.
  function automatic logic [31:0] model_word(input bundle_t b);
    longint unsigned w;
    case (b.fmt)
      2'd0: w = b.opc * 64'd67108864 + b.rs * 64'd2097152 + b.rt * 64'd65536
              + b.rd * 64'd2048 + b.sa * 64'd64 + 64'(b.fun);
      2'd1: w = b.opc * 64'd67108864 + b.rs * 64'd2097152 + b.rt * 64'd65536
              + 64'(b.imm);
      2'd2: w = b.opc * 64'd67108864 + 64'(b.iindex);
      default: w = 64'(b.raw);
    endcase
    return w[31:0];
  endfunction

  function automatic bundle_t cur_bundle();
    bundle_t b;
    b.fmt = bus.fmt; b.opc = bus.opc; b.rs = bus.rs; b.rt = bus.rt;
    b.rd = bus.rd; b.sa = bus.sa; b.fun = bus.fun; b.imm = bus.imm;
    b.iindex = bus.iindex; b.raw = bus.raw; b.last = bus.last;
    return b;
  endfunction

  function automatic wr_t get_wr(input int idx);
    wr_t w;
    if (idx < log_q.size()) w = log_q[idx];
    else begin w.addr = -1; w.data = 'x; end
    return w;
  endfunction

  // Memory responder
  initial begin
    bus.mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      bus.mem_ack = ($urandom_range(99) < ack_prob);
    end
  end

  // Model update on every rising edge; compare 1ns later.
  initial begin : compare
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_busy = 0; m_have = 0; m_done = 0; m_full = 0; m_last = 0;
        m_ptr = BASE_ADDR; m_count = 0; m_wdata = '0;
      end else begin
        if (p_we && bus.mem_ack) log_q.push_back('{int'(p_addr), p_data});
        if (m_done) begin
          m_done = 0; m_busy = 0;
        end else if (!m_busy) begin
          if (start) begin
            m_busy = 1; m_ptr = BASE_ADDR; m_count = 0; m_full = 0;
          end
        end else if (!m_have) begin
          if (bus.in_valid) begin
            m_have = 1; m_wdata = model_word(cur_bundle()); m_last = bus.last;
          end
        end else if (bus.mem_ack) begin
          m_have = 0;
          m_count++;
          if (m_last) m_done = 1;
          else if (m_ptr == DEPTH - 1) begin m_full = 1; m_done = 1; end
          else m_ptr++;
        end
      end
      #1;
      chk("busy",      busy,          m_busy);
      chk("in_ready",  bus.in_ready,  m_busy && !m_have && !m_done);
      chk("mem_we",    bus.mem_we,    m_have);
      chk("done",      done,          m_done);
      chk("full",      full,          m_full);
      chk("count",     count,         m_count);
      chk("mem_addr",  bus.mem_addr,  m_ptr);
      chk("mem_wdata", bus.mem_wdata, m_wdata);
      p_we = bus.mem_we; p_addr = bus.mem_addr; p_data = bus.mem_wdata;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    start = spam && busy && ($urandom_range(5) == 0);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic apply(input bundle_t b);
    bus.fmt = b.fmt; bus.opc = b.opc; bus.rs = b.rs; bus.rt = b.rt;
    bus.rd = b.rd; bus.sa = b.sa; bus.fun = b.fun; bus.imm = b.imm;
    bus.iindex = b.iindex; bus.raw = b.raw; bus.last = b.last;
  endtask

  task automatic drive_bundle(input bundle_t b, input int max_wait, output bit acc);
    tick();
    apply(b);
    bus.in_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < max_wait && !acc; i++) begin
      if (bus.in_ready) acc = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_wait, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_wait && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
  endtask

  task automatic wait_idle(input string name, input int max_wait);
    bit ok = 1'b0;
    for (int i = 0; i < max_wait && !ok; i++) begin
      tick();
      if (!busy) ok = 1'b1;
    end
    chk(name, ok, 1'b1);
  endtask

  function automatic bundle_t mk(input logic [1:0] f, input logic [5:0] op,
                                 input logic [4:0] r_s, input logic [4:0] r_t,
                                 input logic [4:0] r_d, input logic [4:0] sh,
                                 input logic [5:0] fn, input logic [15:0] im,
                                 input logic [25:0] idx, input logic [31:0] rw,
                                 input logic lst);
    bundle_t b;
    b.fmt = f; b.opc = op; b.rs = r_s; b.rt = r_t; b.rd = r_d; b.sa = sh;
    b.fun = fn; b.imm = im; b.iindex = idx; b.raw = rw; b.last = lst;
    return b;
  endfunction

  initial begin : main
    bundle_t b;
    bit acc, seen;
    int base, nacc, nb;
    bit uselast;
    logic [127:0] r;
    wr_t w;

    apply('0);
    bus.in_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);       chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_mem_we", bus.mem_we, 0); chk("rst_done", done, 0);
    chk("rst_full", full, 0);       chk("rst_count", count, 0);
    chk("rst_addr", bus.mem_addr, BASE_ADDR); chk("rst_wdata", bus.mem_wdata, 0);
    rst_n = 1'b1;

    // R-type, immediate ack, start during done is dropped
    ack_prob = 100;
    base = log_q.size();
    pulse_start();
    drive_bundle(mk(2'd0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0, 32'd0, 1'b1), 20, acc);
    chk("rtype_accept", acc, 1);
    wait_done(20, seen);
    chk("rtype_done", seen, 1);
    start = 1'b1;
    tick();
    chk("start_in_done_ignored", busy, 0);
    tick();
    chk("start_in_done_still_idle", busy, 0);
    chk("rtype_nwrites", log_q.size() - base, 1);
    w = get_wr(base);
    chk("rtype_addr", w.addr, 0);
    chk("rtype_data", w.data, 32'h00221820);
    chk("rtype_count", count, 1);

    // Mixed I/J burst
    base = log_q.size();
    pulse_start();
    drive_bundle(mk(2'd1, 6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0, 32'd0, 1'b0), 20, acc);
    chk("mix_accept0", acc, 1);
    drive_bundle(mk(2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0000100, 32'd0, 1'b1), 20, acc);
    chk("mix_accept1", acc, 1);
    wait_done(20, seen);
    chk("mix_done", seen, 1);
    chk("mix_nwrites", log_q.size() - base, 2);
    w = get_wr(base);     chk("mix_addr0", w.addr, 0); chk("mix_data0", w.data, 32'h2022FFFF);
    w = get_wr(base + 1); chk("mix_addr1", w.addr, 1); chk("mix_data1", w.data, 32'h08000100);
    tick();
    chk("mix_count", count, 2);

    // Backpressure: write port held for 6 cycles with ack low
    ack_prob = 0;
    tick(); tick();
    pulse_start();
    drive_bundle(mk(2'd3, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 32'hDEADBEEF, 1'b1), 20, acc);
    chk("bp_accept", acc, 1);
    for (int i = 0; i < 6; i++) begin
      chk("bp_we", bus.mem_we, 1);
      chk("bp_addr", bus.mem_addr, 0);
      chk("bp_wdata", bus.mem_wdata, 32'hDEADBEEF);
      chk("bp_in_ready", bus.in_ready, 0);
      if (i < 5) tick();
    end
    ack_prob = 100;
    wait_done(20, seen);
    chk("bp_done", seen, 1);
    chk("bp_count", count, 1);

    // Exhaustion: 5 bundles without last
    tick();
    base = log_q.size();
    nacc = 0;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      drive_bundle(mk(2'd3, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 32'hA0 + i, 1'b0), 12, acc);
      if (acc) nacc++;
    end
    chk("exh_accepted", nacc, 4);
    chk("exh_nwrites", log_q.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      w = get_wr(base + i);
      chk("exh_addr", w.addr, i);
      chk("exh_data", w.data, 32'hA0 + i);
    end
    chk("exh_full", full, 1);
    chk("exh_count", count, 4);
    chk("exh_idle", busy, 0);

    // Reset during the second write of a session
    pulse_start();
    drive_bundle(mk(2'd3, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 32'h11111111, 1'b0), 20, acc);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (bus.in_ready) seen = 1'b1;
    end
    chk("rstw_back_to_accept", seen, 1);
    ack_prob = 0;
    drive_bundle(mk(2'd3, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 32'h22222222, 1'b0), 20, acc);
    chk("rstw_we_before", bus.mem_we, 1);
    chk("rstw_addr_before", bus.mem_addr, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstw_busy", busy, 0);        chk("rstw_in_ready", bus.in_ready, 0);
    chk("rstw_mem_we", bus.mem_we, 0); chk("rstw_done", done, 0);
    chk("rstw_full", full, 0);        chk("rstw_count", count, 0);
    chk("rstw_addr", bus.mem_addr, BASE_ADDR); chk("rstw_wdata", bus.mem_wdata, 0);
    tick();
    rst_n = 1'b1;
    ack_prob = 100;
    base = log_q.size();
    pulse_start();
    drive_bundle(mk(2'd3, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 32'h12345678, 1'b1), 20, acc);
    wait_done(20, seen);
    chk("rstw_new_done", seen, 1);
    chk("rstw_new_nwrites", log_q.size() - base, 1);
    w = get_wr(base);
    chk("rstw_new_addr", w.addr, BASE_ADDR);
    chk("rstw_new_data", w.data, 32'h12345678);
    tick();

    // Randomized sessions
    spam = 1'b1;
    for (int s = 0; s < 60; s++) begin
      case ($urandom_range(2))
        0: ack_prob = 100;
        1: ack_prob = 60;
        default: ack_prob = 25;
      endcase
      pulse_start();
      uselast = ($urandom_range(3) != 0);
      nb = uselast ? int'($urandom_range(1, 6)) : 6;
      for (int k = 0; k < nb; k++) begin
        repeat ($urandom_range(0, 2)) tick();
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        b = r[$bits(bundle_t)-1:0];
        b.last = uselast && (k == nb - 1);
        drive_bundle(b, 30, acc);
        if (!acc) break;
      end
      wait_idle("rand_session_end", 80);
    end
    spam = 1'b0;
    start = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
